// File: rtl/jtkicker_objscan.sv
// jtkicker_objscan: per-line object table walker that issues sprite draw requests.
// Define JTKICKER_OBJLIMIT_EN to cap draws per line at MAX_LINE and flag ovf.
module jtkicker_objscan #(
  parameter int OBJ_N     = 24,
  parameter int OBJ_H     = 16,
  parameter int REV_SCAN  = 1,
  parameter int ADJ_SPLIT = 19,
  parameter int LARGE_ROM = 0,
  parameter int MAX_LINE  = 16,
  localparam int VW = $clog2(OBJ_H),
  localparam int AW = $clog2(OBJ_N) + 1
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          hinit,
  input  logic [7:0]    vrender,
  input  logic          flip,
  output logic [AW-1:0] tbl_addr,
  input  logic [7:0]    tbl_lo,
  input  logic [7:0]    tbl_hi,
  input  logic          dr_busy,
  output logic          dr_start,
  output logic [8:0]    dr_code,
  output logic [7:0]    dr_xpos,
  output logic [7:0]    dr_attr,
  output logic [VW-1:0] dr_v,
  output logic          scan_busy,
  output logic          ovf
);
  localparam int IW = AW - 1;
  localparam logic [IW-1:0] FIRST = REV_SCAN != 0 ? IW'(OBJ_N - 1) : '0;
  localparam logic [IW-1:0] LAST  = REV_SCAN != 0 ? '0 : IW'(OBJ_N - 1);
`ifdef JTKICKER_OBJLIMIT_EN
  localparam bit LIM_EN = 1'b1;
`else
  localparam bit LIM_EN = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, ATTR, CODE, GAP} state_t;
  state_t        r_st;
  logic [IW-1:0] r_idx;
  logic          r_byte, r_hin_l, r_hinit_x;
  logic [6:0]    r_cnt;
  logic [7:0]    w_vrf, w_dry, w_ydiff;
  logic          w_adj, w_inzone, w_lim;
  assign w_vrf    = vrender ^ {8{flip}};
  assign w_adj    = REV_SCAN != 0 ? 32'(r_idx) < ADJ_SPLIT : 32'(r_idx) > ADJ_SPLIT;
  assign w_dry    = ~tbl_lo + (w_adj ? (flip ? 8'hFF : 8'h01) : 8'h00);
  // 9-bit upper bound so objects straddling line 255 never wrap onto line 0
  assign w_inzone = w_dry >= w_vrf && {1'b0, w_dry} < {1'b0, w_vrf} + 9'(OBJ_H);
  assign w_ydiff  = w_vrf - w_dry - 8'd1;
  assign w_lim    = LIM_EN && 32'(r_cnt) >= MAX_LINE;
  assign tbl_addr  = {r_idx, r_byte};
  assign scan_busy = r_st != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_st      <= IDLE;
      r_idx     <= '0;
      r_byte    <= 1'b0;
      r_hin_l   <= 1'b0;
      r_hinit_x <= 1'b0;
      r_cnt     <= '0;
      dr_start  <= 1'b0;
      ovf       <= 1'b0;
      dr_code   <= '0;
      dr_xpos   <= '0;
      dr_attr   <= '0;
      dr_v      <= '0;
    end else begin
      r_hin_l <= hinit;
      if (hinit && !r_hin_l) r_hinit_x <= 1'b1;
      else if (cen) r_hinit_x <= 1'b0;
      if (cen) begin
        dr_start <= 1'b0;
        if (r_hinit_x) begin
          r_st   <= ATTR;
          r_idx  <= FIRST;
          r_byte <= 1'b0;
          r_cnt  <= '0;
          ovf    <= 1'b0;
        end else case (r_st)
          ATTR: if (!dr_busy) begin
            dr_xpos <= tbl_hi;
            dr_attr <= tbl_lo;
            r_byte  <= 1'b1;
            r_st    <= CODE;
          end
          CODE: begin
            dr_code <= {LARGE_ROM != 0 && dr_attr[0], tbl_hi};
            dr_v    <= w_ydiff[VW-1:0];
            r_idx   <= REV_SCAN != 0 ? r_idx - IW'(1) : r_idx + IW'(1);
            r_byte  <= 1'b0;
            if (w_inzone && !w_lim) begin
              dr_start <= 1'b1;
              r_cnt    <= r_cnt + 7'd1;
            end
            if (w_inzone && w_lim) ovf <= 1'b1;
            r_st <= r_idx == LAST ? IDLE : GAP;
          end
          GAP: r_st <= ATTR;
          default: ;
        endcase
      end
    end
  end
endmodule
